// File: rtl/switch_pkg.sv
// switch_pkg: switch-wide port count and address/port types
package switch_pkg;
    localparam int NUM_PORTS = 8;
    localparam int PORT_W = $clog2(NUM_PORTS);
    typedef logic [47:0] mac_addr_t;
    typedef logic [PORT_W-1:0] port_idx_t;
endpackage

// File: rtl/address_table_victim_sel.sv
// address_table_victim_sel: picks the first free slot and the least-read slot of the table
module address_table_victim_sel #(
    parameter int DEPTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic [DEPTH-1:0]              i_valid,
    input  logic [DEPTH-1:0][COUNT_W-1:0] i_count,
    output logic [$clog2(DEPTH)-1:0]      o_free_idx,
    output logic                          o_full,
    output logic [$clog2(DEPTH)-1:0]      o_min_idx
);
    localparam int IDX_W = $clog2(DEPTH);
    logic [COUNT_W-1:0] w_min;
    assign o_full = &i_valid;
    // downward scan for the free slot and strict-less upward scan for the minimum both favour the lowest index
    always_comb begin
        o_free_idx = '0;
        o_min_idx  = '0;
        w_min      = i_count[0];
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!i_valid[i]) o_free_idx = IDX_W'(i);
        for (int i = 1; i < DEPTH; i++)
            if (i_count[i] < w_min) begin
                w_min     = i_count[i];
                o_min_idx = IDX_W'(i);
            end
    end
endmodule

// File: rtl/address_table.sv
// address_table: MAC learning table with least-frequently-read replacement; ADDRESS_TABLE_MCAST_FILTER_EN drops group-address learns
module address_table
    import switch_pkg::*;
#(
    parameter int TABLE_DEPTH = 16,
    parameter int COUNT_W     = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      learn_req_i,
    input  mac_addr_t learn_address_i,
    input  port_idx_t learn_port_i,
    input  logic      read_req_i,
    input  mac_addr_t read_address_i,
    output port_idx_t read_port_o,
    output logic      read_port_valid_o
);
    localparam int IDX_W = $clog2(TABLE_DEPTH);
    logic [TABLE_DEPTH-1:0]              r_valid;
    mac_addr_t                           r_addr [TABLE_DEPTH];
    port_idx_t                           r_port [TABLE_DEPTH];
    logic [TABLE_DEPTH-1:0][COUNT_W-1:0] r_count;
    logic [TABLE_DEPTH-1:0]              w_read_hit;
    logic [TABLE_DEPTH-1:0]              w_learn_hit;
    logic [IDX_W-1:0]                    w_read_idx;
    logic [IDX_W-1:0]                    w_learn_idx;
    logic [IDX_W-1:0]                    w_free_idx;
    logic [IDX_W-1:0]                    w_min_idx;
    logic [IDX_W-1:0]                    w_target;
    logic                                w_full;
    logic                                w_learn_en;
`ifdef ADDRESS_TABLE_MCAST_FILTER_EN
    assign w_learn_en = learn_req_i & ~learn_address_i[40];
`else
    assign w_learn_en = learn_req_i;
`endif
    // parallel match of both request addresses; stored addresses are unique so at most one hit each
    always_comb begin
        w_read_hit  = '0;
        w_learn_hit = '0;
        w_read_idx  = '0;
        w_learn_idx = '0;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            w_read_hit[i]  = r_valid[i] && r_addr[i] == read_address_i;
            w_learn_hit[i] = r_valid[i] && r_addr[i] == learn_address_i;
            if (w_read_hit[i]) w_read_idx = IDX_W'(i);
            if (w_learn_hit[i]) w_learn_idx = IDX_W'(i);
        end
    end
    address_table_victim_sel #(
        .DEPTH   (TABLE_DEPTH),
        .COUNT_W (COUNT_W)
    ) u_victim_sel (
        .i_valid    (r_valid),
        .i_count    (r_count),
        .o_free_idx (w_free_idx),
        .o_full     (w_full),
        .o_min_idx  (w_min_idx)
    );
    assign w_target = |w_learn_hit ? w_learn_idx : (w_full ? w_min_idx : w_free_idx);
    // lookup result registers and per-entry update; a learn into the read-hit entry suppresses its increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid           <= '0;
            r_count           <= '0;
            read_port_o       <= '0;
            read_port_valid_o <= 1'b0;
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                r_addr[i] <= '0;
                r_port[i] <= '0;
            end
        end else begin
            if (read_req_i) begin
                read_port_valid_o <= |w_read_hit;
                read_port_o       <= |w_read_hit ? r_port[w_read_idx] : '0;
            end
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                if (w_learn_en && w_target == IDX_W'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_addr[i]  <= learn_address_i;
                    r_port[i]  <= learn_port_i;
                    if (!w_learn_hit[i]) r_count[i] <= '0;
                end else if (read_req_i && w_read_hit[i] && !(&r_count[i])) begin
                    r_count[i] <= r_count[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_address_table.sv
// tb_address_table: directed checks of learning, lookup, replacement order and reset
module tb_address_table;
    import switch_pkg::*;
    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      learn_req_i = 1'b0;
    mac_addr_t learn_address_i = '0;
    port_idx_t learn_port_i = '0;
    logic      read_req_i = 1'b0;
    mac_addr_t read_address_i = '0;
    port_idx_t read_port_o;
    logic      read_port_valid_o;
    int        n_cmp = 0;
    int        n_err = 0;

    always #5 clk = ~clk;

    address_table dut (
        .clk               (clk),
        .rst               (rst),
        .learn_req_i       (learn_req_i),
        .learn_address_i   (learn_address_i),
        .learn_port_i      (learn_port_i),
        .read_req_i        (read_req_i),
        .read_address_i    (read_address_i),
        .read_port_o       (read_port_o),
        .read_port_valid_o (read_port_valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input mac_addr_t a);
        read_req_i = 1'b1;
        read_address_i = a;
        @(negedge clk);
        read_req_i = 1'b0;
    endtask

    task automatic lrn(input mac_addr_t a, input port_idx_t p);
        learn_req_i = 1'b1;
        learn_address_i = a;
        learn_port_i = p;
        @(negedge clk);
        learn_req_i = 1'b0;
    endtask

    task automatic rdchk(input string tag, input mac_addr_t a, input logic v, input port_idx_t p);
        rd(a);
        chk({tag, "_valid"}, 32'(read_port_valid_o), 32'(v));
        chk({tag, "_port"}, 32'(read_port_o), 32'(p));
    endtask

    initial begin
        #1;
        chk("reset_valid", 32'(read_port_valid_o), 0);
        chk("reset_port", 32'(read_port_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdchk("empty_miss", 48'h1001, 1'b0, 0);
        // fill: each entry readable on the cycle right after its learn; every entry ends with count 1
        for (int i = 1; i <= 16; i++) begin
            lrn(48'h1000 + 48'(i), port_idx_t'(i % NUM_PORTS));
            rdchk("fill", 48'h1000 + 48'(i), 1'b1, port_idx_t'(i % NUM_PORTS));
        end
        // bring address 0x1000+i to i+2 reads: slot s holds s+3
        for (int i = 1; i <= 16; i++)
            for (int k = 0; k < i + 1; k++) rd(48'h1000 + 48'(i));
        // each replacement is read 20 times so it is not the next victim
        for (int i = 17; i <= 20; i++) begin
            lrn(48'h1000 + 48'(i), port_idx_t'(i % NUM_PORTS));
            for (int k = 0; k < 20; k++) rd(48'h1000 + 48'(i));
        end
        for (int i = 1; i <= 4; i++) rdchk("evicted_low", 48'h1000 + 48'(i), 1'b0, 0);
        for (int i = 5; i <= 20; i++) rdchk("kept", 48'h1000 + 48'(i), 1'b1, port_idx_t'(i % NUM_PORTS));
        @(negedge clk);
        @(negedge clk);
        chk("hold_valid", 32'(read_port_valid_o), 1);
        chk("hold_port", 32'(read_port_o), 4);
        // relearn 0x1010 (count 19 -> 20 after this read); must keep its count so it survives later evictions
        lrn(48'h1010, 3'd7);
        rdchk("relearn", 48'h1010, 1'b1, 3'd7);
        for (int i = 8; i <= 11; i++)
            for (int k = 0; k < 10; k++) rd(48'h1000 + 48'(i));
        // 0x1005 and 0x1006 now both at 9: tie goes to the lower slot
        rdchk("tie_prep", 48'h1005, 1'b1, 3'd5);
        for (int j = 1; j <= 4; j++) begin
            lrn(48'h2000 + 48'(j), port_idx_t'((j + 4) % NUM_PORTS));
            for (int k = 0; k < 30; k++) rd(48'h2000 + 48'(j));
        end
        rdchk("evict_tie", 48'h1005, 1'b0, 0);
        rdchk("evict_2", 48'h1006, 1'b0, 0);
        rdchk("evict_3", 48'h1007, 1'b0, 0);
        rdchk("evict_4", 48'h100C, 1'b0, 0);
        for (int i = 8; i <= 11; i++) rdchk("busy_kept", 48'h1000 + 48'(i), 1'b1, port_idx_t'(i % NUM_PORTS));
        for (int j = 1; j <= 4; j++) rdchk("new_kept", 48'h2000 + 48'(j), 1'b1, port_idx_t'((j + 4) % NUM_PORTS));
        rdchk("relearn_kept", 48'h1010, 1'b1, 3'd7);
        rdchk("kept_100d", 48'h100D, 1'b1, 3'd5);
        // same-cycle learn and read of one entry: lookup returns the old port
        read_req_i = 1'b1;
        read_address_i = 48'h1010;
        lrn(48'h1010, 3'd3);
        read_req_i = 1'b0;
        chk("simul_valid", 32'(read_port_valid_o), 1);
        chk("simul_port", 32'(read_port_o), 7);
        rdchk("simul_after", 48'h1010, 1'b1, 3'd3);
`ifdef ADDRESS_TABLE_MCAST_FILTER_EN
        lrn(48'h0100_0000_0001, 3'd2);
        rdchk("mcast_drop", 48'h0100_0000_0001, 1'b0, 0);
        rdchk("mcast_no_evict", 48'h100D, 1'b1, 3'd5);
`else
        lrn(48'h0100_0000_0001, 3'd2);
        rdchk("mcast_learn", 48'h0100_0000_0001, 1'b1, 3'd2);
`endif
        rdchk("pre_reset", 48'h1008, 1'b1, 3'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(read_port_valid_o), 0);
        chk("async_rst_port", 32'(read_port_o), 0);
        @(negedge clk);
        rst = 1'b0;
        rdchk("post_reset", 48'h1008, 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
